// File: rtl/c2_sweep_pkg.sv
// Shared types and sizes for the C2 exhaustive sweep driver.
// The C2_SWEEP_COMPARE_EN build option is consumed by c2_sweep_driver.
package c2_sweep_pkg;

  localparam int VEC_N = 16;
  localparam int IDX_W = 4;
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/c2_sweep_timer.sv
// Loadable 4-bit down-counter that paces each select vector of the sweep.
// o_expire is high while the count sits at zero.
module c2_sweep_timer #(
  parameter int SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expire
);

  logic [3:0] r_count;

  // Saturates at zero so an idle timer stays expired until reloaded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= 4'(SETTLE);
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_expire = (r_count == 4'd0);

endmodule

// File: rtl/c2_sweep_driver.sv
// Exhaustive sweep of one C2 cell: steps the 16 select codes and captures out.
// Define C2_SWEEP_COMPARE_EN to build the golden compare and error counter.
module c2_sweep_driver
  import c2_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_cfg,
  input  logic [VEC_N-1:0] i_golden,
  input  logic             i_c2_out,
  output logic             o_D00,
  output logic             o_D01,
  output logic             o_D10,
  output logic             o_D11,
  output logic             o_A0,
  output logic             o_A1,
  output logic             o_B0,
  output logic             o_B1,
  output logic             o_busy,
  output logic             o_done,
  output logic [VEC_N-1:0] o_resp,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_err_count
);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_cfg;
  logic [VEC_N-1:0] r_resp;
  logic             w_expire;
  logic             w_accept;
  logic             w_sample;
  logic             w_last;
  logic             w_load;
  logic             w_drive;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_sample = (r_state == DRIVE) && w_expire;
  assign w_last   = (r_idx == IDX_W'(VEC_N - 1));
  assign w_load   = w_accept || (w_sample && !w_last);
  assign w_drive  = (r_state == DRIVE);

  c2_sweep_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = DRIVE;
      DRIVE:   if (w_sample && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Each vector's sample lands in its own resp bit; a new start clears the word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg  <= 4'd0;
      r_idx  <= '0;
      r_resp <= '0;
    end else if (w_accept) begin
      r_cfg  <= i_cfg;
      r_idx  <= '0;
      r_resp <= '0;
    end else if (w_sample) begin
      r_resp[r_idx] <= i_c2_out;
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef C2_SWEEP_COMPARE_EN
  logic [ERR_W-1:0] r_err;
  logic             r_mismatch;
  logic [ERR_W-1:0] w_errNext;

  assign w_errNext = r_err + ERR_W'(i_c2_out ^ i_golden[r_idx]);

  // A non-zero error count is exactly resp != golden, so mismatch follows it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else if (w_sample) begin
      r_err <= w_errNext;
      if (w_last) begin
        r_mismatch <= (w_errNext != '0);
      end
    end
  end

  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_err;
`else
  logic w_unused_golden;
  assign w_unused_golden = ^i_golden;
  assign o_mismatch  = 1'b0;
  assign o_err_count = '0;
`endif

  assign o_D00  = r_cfg[0];
  assign o_D01  = r_cfg[1];
  assign o_D10  = r_cfg[2];
  assign o_D11  = r_cfg[3];
  assign o_A0   = w_drive & r_idx[0];
  assign o_A1   = w_drive & r_idx[1];
  assign o_B0   = w_drive & r_idx[2];
  assign o_B1   = w_drive & r_idx[3];
  assign o_busy = w_drive;
  assign o_done = (r_state == DONE);
  assign o_resp = r_resp;

endmodule
